// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: word sizes, ALU opcodes and
// the control bundle carried from decode into execute.
package riscv_pkg;

   localparam int XLEN    = 32;
   localparam int REG_IDX = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_t;

   typedef struct packed {
      alu_op_t alu_op;
      logic    reg_we;
      logic    mem_rd;
      logic    mem_wr;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode inputs, bypass sources and the
// registered execute-side outputs with counters.
interface id_ex_stage_if
   import riscv_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int INDEX = REG_IDX,
   parameter int CNT_W = 16
);
   logic             id_valid_in;
   logic [WIDTH-1:0] id_pc_in;
   logic [WIDTH-1:0] id_imm_in;
   logic [INDEX-1:0] id_rs1_in;
   logic [INDEX-1:0] id_rs2_in;
   logic             id_uses_rs1_in;
   logic             id_uses_rs2_in;
   logic [INDEX-1:0] id_rd_in;
   ctrl_t            id_ctrl_in;
   logic [WIDTH-1:0] rf_data_a_in;
   logic [WIDTH-1:0] rf_data_b_in;
   logic [WIDTH-1:0] ex_result_in;
   logic             mem_we_in;
   logic [INDEX-1:0] mem_rd_in;
   logic [WIDTH-1:0] mem_result_in;
   logic             flush_in;
   logic             stall_out;
   logic             ex_valid_out;
   logic [WIDTH-1:0] ex_pc_out;
   logic [WIDTH-1:0] ex_imm_out;
   logic [WIDTH-1:0] ex_op_a_out;
   logic [WIDTH-1:0] ex_op_b_out;
   logic [INDEX-1:0] ex_rd_out;
   ctrl_t            ex_ctrl_out;
   logic [CNT_W-1:0] stall_cnt_out;
   logic [CNT_W-1:0] flush_cnt_out;

   modport master (
      output id_valid_in, id_pc_in, id_imm_in,
      output id_rs1_in, id_rs2_in,
      output id_uses_rs1_in, id_uses_rs2_in,
      output id_rd_in, id_ctrl_in,
      output rf_data_a_in, rf_data_b_in,
      output ex_result_in,
      output mem_we_in, mem_rd_in, mem_result_in,
      output flush_in,
      input  stall_out, ex_valid_out,
      input  ex_pc_out, ex_imm_out,
      input  ex_op_a_out, ex_op_b_out,
      input  ex_rd_out, ex_ctrl_out,
      input  stall_cnt_out, flush_cnt_out
   );

   modport slave (
      input  id_valid_in, id_pc_in, id_imm_in,
      input  id_rs1_in, id_rs2_in,
      input  id_uses_rs1_in, id_uses_rs2_in,
      input  id_rd_in, id_ctrl_in,
      input  rf_data_a_in, rf_data_b_in,
      input  ex_result_in,
      input  mem_we_in, mem_rd_in, mem_result_in,
      input  flush_in,
      output stall_out, ex_valid_out,
      output ex_pc_out, ex_imm_out,
      output ex_op_a_out, ex_op_b_out,
      output ex_rd_out, ex_ctrl_out,
      output stall_cnt_out, flush_cnt_out
   );

endinterface

// File: rtl/operand_fwd_mux.sv
// Priority bypass select for one source operand:
// x0, then EX result, then MEM result, then register file.
module operand_fwd_mux #(
   parameter int WIDTH = 32,
   parameter int INDEX = 5
) (
   input  logic [INDEX-1:0] rs,
   input  logic             ex_fwd_en,
   input  logic [INDEX-1:0] ex_rd,
   input  logic [WIDTH-1:0] ex_result,
   input  logic             mem_we,
   input  logic [INDEX-1:0] mem_rd,
   input  logic [WIDTH-1:0] mem_result,
   input  logic [WIDTH-1:0] rf_data,
   output logic [WIDTH-1:0] operand
);

   // Youngest producer wins; x0 is hardwired to zero.
   always_comb begin
      operand = rf_data;
      if (rs == '0)
         operand = '0;
      else if (ex_fwd_en && (ex_rd == rs))
         operand = ex_result;
      else if (mem_we && (mem_rd == rs))
         operand = mem_result;
   end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with bypassing,
// load-use bubble, flush squash and perf counters.
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int INDEX = REG_IDX,
   parameter int CNT_W = 16
) (
   input logic          clk_in,
   input logic          rst_in,
   id_ex_stage_if.slave bus
);

   logic             ex_valid_q;
   logic [WIDTH-1:0] ex_pc_q;
   logic [WIDTH-1:0] ex_imm_q;
   logic [WIDTH-1:0] ex_op_a_q;
   logic [WIDTH-1:0] ex_op_b_q;
   logic [INDEX-1:0] ex_rd_q;
   ctrl_t            ex_ctrl_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   logic             hz;
   logic             stall;
   logic             bubble;
   logic             ex_fwd_en;
   logic             rs1_hit;
   logic             rs2_hit;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   // Load in EX whose data is not ready yet blocks a dependent ID.
   always_comb begin
      rs1_hit = bus.id_uses_rs1_in && (bus.id_rs1_in == ex_rd_q);
      rs2_hit = bus.id_uses_rs2_in && (bus.id_rs2_in == ex_rd_q);
      hz      = bus.id_valid_in && ex_valid_q &&
                ex_ctrl_q.mem_rd && (ex_rd_q != '0) &&
                (rs1_hit || rs2_hit);
      stall   = hz && !bus.flush_in;
      bubble  = rst_in || bus.flush_in ||
                stall || !bus.id_valid_in;
      ex_fwd_en = ex_valid_q && ex_ctrl_q.reg_we &&
                  !ex_ctrl_q.mem_rd;
   end

   operand_fwd_mux #(.WIDTH(WIDTH), .INDEX(INDEX)) u_fwd_a (
      .rs         (bus.id_rs1_in),
      .ex_fwd_en  (ex_fwd_en),
      .ex_rd      (ex_rd_q),
      .ex_result  (bus.ex_result_in),
      .mem_we     (bus.mem_we_in),
      .mem_rd     (bus.mem_rd_in),
      .mem_result (bus.mem_result_in),
      .rf_data    (bus.rf_data_a_in),
      .operand    (op_a)
   );

   operand_fwd_mux #(.WIDTH(WIDTH), .INDEX(INDEX)) u_fwd_b (
      .rs         (bus.id_rs2_in),
      .ex_fwd_en  (ex_fwd_en),
      .ex_rd      (ex_rd_q),
      .ex_result  (bus.ex_result_in),
      .mem_we     (bus.mem_we_in),
      .mem_rd     (bus.mem_rd_in),
      .mem_result (bus.mem_result_in),
      .rf_data    (bus.rf_data_b_in),
      .operand    (op_b)
   );

   // EX register: capture ID or insert an all-zero bubble.
   always_ff @(posedge clk_in) begin
      if (bubble) begin
         ex_valid_q <= 1'b0;
         ex_pc_q    <= '0;
         ex_imm_q   <= '0;
         ex_op_a_q  <= '0;
         ex_op_b_q  <= '0;
         ex_rd_q    <= '0;
         ex_ctrl_q  <= CTRL_BUBBLE;
      end else begin
         ex_valid_q <= 1'b1;
         ex_pc_q    <= bus.id_pc_in;
         ex_imm_q   <= bus.id_imm_in;
         ex_op_a_q  <= op_a;
         ex_op_b_q  <= op_b;
         ex_rd_q    <= bus.id_rd_in;
         ex_ctrl_q  <= bus.id_ctrl_in;
      end
   end

   // Saturating bubble counters, cleared only by reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (bus.flush_in && bus.id_valid_in &&
             (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign bus.stall_out     = stall;
   assign bus.ex_valid_out  = ex_valid_q;
   assign bus.ex_pc_out     = ex_pc_q;
   assign bus.ex_imm_out    = ex_imm_q;
   assign bus.ex_op_a_out   = ex_op_a_q;
   assign bus.ex_op_b_out   = ex_op_b_q;
   assign bus.ex_rd_out     = ex_rd_q;
   assign bus.ex_ctrl_out   = ex_ctrl_q;
   assign bus.stall_cnt_out = stall_cnt_q;
   assign bus.flush_cnt_out = flush_cnt_q;

endmodule
